store_align_buffer: RTL and testbench

Store-side counterpart of the load data extender in the MEM stage. Takes sw/sh/sb requests, checks alignment, and raises an address-error-on-store (AdES) report for misaligned requests. Replicates the store data across byte lanes and generates byte enables. Queues aligned stores in a small FIFO that drains to the data memory/bridge over a valid/ready handshake.

---
 rtl/store_align_buffer_pkg.sv | 18 +
 rtl/store_lane_align.sv | 39 +++
 rtl/store_align_buffer.sv | 113 +++++++++++
 tb/tb_store_align_buffer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/store_align_buffer_pkg.sv
// Shared store-path definitions for the MEM stage: store-select codes,
// byte-enable patterns and the lane-aligned payload type held in the store buffer.
package store_align_buffer_pkg;

    localparam logic [1:0] SW_SEL = 2'b00;
    localparam logic [1:0] SH_SEL = 2'b01;
    localparam logic [1:0] SB_SEL = 2'b10;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HLO  = 4'b0011;
    localparam logic [3:0] BE_HHI  = 4'b1100;

    typedef struct packed {
        logic [31:0] wdata;
        logic [3:0]  be;
    } lane_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational store lane steering: replicates store data across byte lanes,
// builds byte enables and flags misaligned or invalid store types.
module store_lane_align
    import store_align_buffer_pkg::*;
(
    input  logic [1:0]  sel_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] data_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic        misaligned_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        wdata_o      = '0;
        be_o         = '0;
        misaligned_o = 1'b1;
        case (sel_i)
            SW_SEL: begin
                wdata_o      = data_i;
                be_o         = BE_WORD;
                misaligned_o = (addr_lo_i != 2'b00);
            end
            SH_SEL: begin
                wdata_o      = {2{data_i[15:0]}};
                be_o         = addr_lo_i[1] ? BE_HHI : BE_HLO;
                misaligned_o = addr_lo_i[0];
            end
            SB_SEL: begin
                wdata_o      = {4{data_i[7:0]}};
                be_o         = 4'b0001 << addr_lo_i;
                misaligned_o = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_align_buffer.sv
// MEM-stage store buffer: alignment check with AdES reporting, lane steering,
// and a small in-order FIFO draining to data memory over valid/ready.
module store_align_buffer
    import store_align_buffer_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_sel,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              ades_err,
    output logic [ADDR_W-1:0] ades_addr,
    output logic              empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ades_err_q;
    logic [ADDR_W-1:0] ades_addr_q;
    logic [ADDR_W-3:0] addr_q [DEPTH];
    lane_t             lane_q [DEPTH];

    lane_t             lane_in;
    logic              misaligned;
    logic              accept;
    logic              enq;
    logic              deq;

    store_lane_align u_lane (
        .sel_i        (req_sel),
        .addr_lo_i    (req_addr[1:0]),
        .data_i       (req_data),
        .wdata_o      (lane_in.wdata),
        .be_o         (lane_in.be),
        .misaligned_o (misaligned)
    );

    assign req_ready = (count_q < FULL_CNT);
    assign mem_valid = (count_q != '0);
    assign empty     = (count_q == '0);

    assign accept = req_valid & req_ready;
    assign enq    = accept & ~misaligned;
    assign deq    = mem_valid & mem_ready;

    // Head entry drives memory directly, so it holds steady while stalled.
    assign mem_addr  = addr_q[rd_ptr_q];
    assign mem_wdata = lane_q[rd_ptr_q].wdata;
    assign mem_be    = lane_q[rd_ptr_q].be;
    assign ades_err  = ades_err_q;
    assign ades_addr = ades_addr_q;

    always_comb begin
        wr_ptr_d = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ades_err_q  <= 1'b0;
            ades_addr_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ades_err_q <= accept & misaligned;
            if (accept & misaligned) begin
                ades_addr_q <= req_addr;
            end
        end
    end

    // NOTE: entry storage is reset so the idle memory bus presents zeros;
    // it therefore maps to flops, not RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                lane_q[i] <= '0;
            end
        end else if (enq) begin
            addr_q[wr_ptr_q] <= req_addr[ADDR_W-1:2];
            lane_q[wr_ptr_q] <= lane_in;
        end
    end

endmodule

// File: tb/tb_store_align_buffer.sv
// Directed bench for store_align_buffer: lane steering, AdES pulses,
// back-pressure, simultaneous enqueue/dequeue and asynchronous reset.
module tb_store_align_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_sel;
    logic        mem_valid;
    logic        mem_ready;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        ades_err;
    logic [31:0] ades_addr;
    logic        empty;

    int total = 0;
    int bad   = 0;

    store_align_buffer #(.DEPTH(2), .ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_sel   (req_sel),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .ades_err  (ades_err),
        .ades_addr (ades_addr),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [1:0] sel, input logic [31:0] addr, input logic [31:0] data);
        req_valid = 1'b1;
        req_sel   = sel;
        req_addr  = addr;
        req_data  = data;
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_sel = 2'b00; mem_ready = 1'b0;
        #12;
        total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL rst_mem_valid got=%b exp=0", mem_valid); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", empty); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
        total++; if ({ades_err, ades_addr} !== 33'h0) begin bad++; $display("FAIL rst_ades got=%b/%h exp=0/0", ades_err, ades_addr); end
        total++; if ({mem_addr, mem_wdata, mem_be} !== 66'h0) begin bad++; $display("FAIL rst_mem_bus got=%h/%h/%b exp=0/0/0", mem_addr, mem_wdata, mem_be); end
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    task automatic test_sb();
        mem_ready = 1'b1;
        do_req(2'b10, 32'h0000_1003, 32'h0000_00AB);
        total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL sb_valid got=%b exp=1", mem_valid); end
        total++; if (mem_addr !== 30'h400) begin bad++; $display("FAIL sb_addr got=%h exp=400", mem_addr); end
        total++; if (mem_be !== 4'b1000) begin bad++; $display("FAIL sb_be got=%b exp=1000", mem_be); end
        total++; if (mem_wdata !== 32'hABAB_ABAB) begin bad++; $display("FAIL sb_wdata got=%h exp=abababab", mem_wdata); end
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL sb_not_empty got=%b exp=0", empty); end
        step();
        total++; if ({empty, mem_valid} !== 2'b10) begin bad++; $display("FAIL sb_drained got=%b%b exp=10", empty, mem_valid); end
    endtask

    task automatic test_sh();
        mem_ready = 1'b0;
        do_req(2'b01, 32'h0000_2002, 32'h0000_1234);
        total++; if (mem_be !== 4'b1100) begin bad++; $display("FAIL sh_hi_be got=%b exp=1100", mem_be); end
        total++; if (mem_wdata !== 32'h1234_1234) begin bad++; $display("FAIL sh_hi_wdata got=%h exp=12341234", mem_wdata); end
        total++; if (mem_addr !== 30'h800) begin bad++; $display("FAIL sh_hi_addr got=%h exp=800", mem_addr); end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        do_req(2'b01, 32'h0000_2000, 32'hFFFF_5678);
        total++; if (mem_be !== 4'b0011) begin bad++; $display("FAIL sh_lo_be got=%b exp=0011", mem_be); end
        total++; if (mem_wdata !== 32'h5678_5678) begin bad++; $display("FAIL sh_lo_wdata got=%h exp=56785678", mem_wdata); end
        mem_ready = 1'b1;
        step();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL sh_drained got=%b exp=1", empty); end
    endtask

    task automatic test_ades();
        mem_ready = 1'b1;
        do_req(2'b00, 32'h0000_3001, 32'hDEAD_BEEF);
        total++; if (ades_err !== 1'b1) begin bad++; $display("FAIL ades_sw_pulse got=%b exp=1", ades_err); end
        total++; if (ades_addr !== 32'h0000_3001) begin bad++; $display("FAIL ades_sw_addr got=%h exp=00003001", ades_addr); end
        total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL ades_sw_no_enq got=%b exp=0", mem_valid); end
        step();
        total++; if (ades_err !== 1'b0) begin bad++; $display("FAIL ades_sw_one_cycle got=%b exp=0", ades_err); end
        total++; if (ades_addr !== 32'h0000_3001) begin bad++; $display("FAIL ades_sw_hold got=%h exp=00003001", ades_addr); end
        do_req(2'b11, 32'h0000_3004, 32'h1111_2222);
        total++; if (ades_err !== 1'b1) begin bad++; $display("FAIL ades_inv_pulse got=%b exp=1", ades_err); end
        total++; if (ades_addr !== 32'h0000_3004) begin bad++; $display("FAIL ades_inv_addr got=%h exp=00003004", ades_addr); end
        total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL ades_inv_no_enq got=%b exp=0", mem_valid); end
        step();
        total++; if (ades_err !== 1'b0) begin bad++; $display("FAIL ades_inv_one_cycle got=%b exp=0", ades_err); end
        do_req(2'b01, 32'h0000_3005, 32'h0);
        total++; if ({ades_err, mem_valid} !== 2'b10) begin bad++; $display("FAIL ades_sh_odd got=%b%b exp=10", ades_err, mem_valid); end
        step();
    endtask

    task automatic test_back_to_back();
        mem_ready = 1'b0;
        req_valid = 1'b1; req_sel = 2'b00; req_addr = 32'h10; req_data = 32'h1111_1111;
        step();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready1 got=%b exp=1", req_ready); end
        req_addr = 32'h14; req_data = 32'h2222_2222;
        step();
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got=%b exp=0", req_ready); end
        req_addr = 32'h18; req_data = 32'h3333_3333;
        step();
        total++; if ({mem_addr, mem_wdata} !== {30'h4, 32'h1111_1111}) begin bad++; $display("FAIL b2b_hold got=%h/%h exp=4/11111111", mem_addr, mem_wdata); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_still_full got=%b exp=0", req_ready); end
        mem_ready = 1'b1;
        step();
        total++; if ({mem_addr, mem_wdata} !== {30'h5, 32'h2222_2222}) begin bad++; $display("FAIL b2b_second got=%h/%h exp=5/22222222", mem_addr, mem_wdata); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_room got=%b exp=1", req_ready); end
        step();
        req_valid = 1'b0;
        total++; if ({mem_valid, mem_addr, mem_wdata} !== {1'b1, 30'h6, 32'h3333_3333}) begin bad++; $display("FAIL b2b_third got=%b/%h/%h exp=1/6/33333333", mem_valid, mem_addr, mem_wdata); end
        step();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_drained got=%b exp=1", empty); end
    endtask

    task automatic test_simul_enq_deq();
        logic [31:0] addrs [5];
        addrs = '{32'h100, 32'h204, 32'h308, 32'h40C, 32'h510};
        mem_ready = 1'b1;
        req_valid = 1'b1;
        req_sel   = 2'b00;
        for (int i = 0; i < 5; i++) begin
            req_addr = addrs[i];
            req_data = 32'hA000_0000 + i;
            step();
            total++;
            if ({mem_valid, req_ready, mem_addr, mem_wdata} !== {2'b11, addrs[i][31:2], 32'hA000_0000 + i}) begin
                bad++;
                $display("FAIL simul_head%0d got=%b%b/%h/%h exp=11/%h/%h", i, mem_valid, req_ready, mem_addr, mem_wdata, addrs[i][31:2], 32'hA000_0000 + i);
            end
        end
        req_valid = 1'b0;
        step();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL simul_drained got=%b exp=1", empty); end
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b0;
        do_req(2'b00, 32'h40, 32'h4040_4040);
        do_req(2'b00, 32'h44, 32'h4444_4444);
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rmid_full got=%b exp=0", req_ready); end
        #2 reset = 1'b0;
        #1;
        total++; if ({mem_valid, empty, ades_err} !== 3'b010) begin bad++; $display("FAIL rmid_async got=%b%b%b exp=010", mem_valid, empty, ades_err); end
        total++; if ({ades_addr, mem_addr} !== 62'h0) begin bad++; $display("FAIL rmid_clear got=%h/%h exp=0/0", ades_addr, mem_addr); end
        #3 reset = 1'b1;
        do_req(2'b00, 32'h20, 32'hCAFE_F00D);
        total++; if ({mem_valid, mem_addr, mem_wdata} !== {1'b1, 30'h8, 32'hCAFE_F00D}) begin bad++; $display("FAIL rmid_new got=%b/%h/%h exp=1/8/cafef00d", mem_valid, mem_addr, mem_wdata); end
        mem_ready = 1'b1;
        step();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rmid_only_entry got=%b exp=1", empty); end
    endtask

    initial begin
        test_reset();
        test_sb();
        test_sh();
        test_ades();
        test_back_to_back();
        test_simul_enq_deq();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
